// File: rtl/am_audio_agc.sv
// am_audio_agc: DC removal, adaptive gain with output saturation, and a small
// first-word-fall-through FIFO feeding the audio sink over valid/ready.
// Samples are qualified by rising edges of demod_clk, which is synchronous to clk.
`timescale 1ns/1ps
module am_audio_agc #(
  parameter int IN_W         = 18,
  parameter int OUT_W        = 16,
  parameter int GAIN_W       = 16,
  parameter int GAIN_FRAC    = 8,
  parameter int GAIN_INIT    = 256,
  parameter int GAIN_MIN     = 16,
  parameter int GAIN_MAX     = 65535,
  parameter int TARGET       = 16384,
  parameter int ATTACK_SHIFT = 4,
  parameter int DECAY_SHIFT  = 10,
  parameter int DC_SHIFT     = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_W-1:0]   demod_in,
  input  logic                     demod_clk,
  output logic signed [OUT_W-1:0]  audio_out,
  output logic                     audio_valid,
  input  logic                     audio_ready,
  output logic [GAIN_W-1:0]        gain_out,
  output logic                     overrun
);

  // Widths: DC accumulator, DC-removed sample, full gain product, FIFO pointers.
  localparam int ACC_W = IN_W + DC_SHIFT + 1;
  localparam int X_W   = IN_W + 1;
  localparam int P_W   = X_W + GAIN_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [GAIN_W-1:0] GAIN_INIT_C = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W:0]   GAIN_MIN_C  = (GAIN_W+1)'(GAIN_MIN);
  localparam logic [GAIN_W:0]   GAIN_MAX_C  = (GAIN_W+1)'(GAIN_MAX);
  localparam logic [OUT_W:0]    TARGET_C    = (OUT_W+1)'(TARGET);
  localparam logic [CNT_W-1:0]  FIFO_FULL_C = CNT_W'(FIFO_DEPTH);
  localparam logic [GAIN_W-1:0] GAIN_ONE_C  = {{(GAIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO_C  = {CNT_W{1'b0}};

  // Clamp a wide signed value into the signed OUT_W audio range.
  // The value fits when every bit from the OUT_W sign position upward agrees.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [P_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if ((&v[P_W-1:OUT_W-1]) || (~|v[P_W-1:OUT_W-1])) begin
      r = v[OUT_W-1:0];
    end else if (v[P_W-1]) begin
      r = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return r;
  endfunction

  // Magnitude of a saturated sample; one extra bit so |-2^(OUT_W-1)| is exact.
  function automatic logic [OUT_W:0] abs_out(input logic signed [OUT_W-1:0] v);
    logic [OUT_W:0] e;
    logic [OUT_W:0] r;
    e = {v[OUT_W-1], v};
    if (v[OUT_W-1]) begin
      r = ~e + {{OUT_W{1'b0}}, 1'b1};
    end else begin
      r = e;
    end
    return r;
  endfunction

  // State registers
  logic                      demod_clk_d_r;
  logic signed [ACC_W-1:0]   dc_acc_r;
  logic signed [X_W-1:0]     x_r;
  logic                      v1_r;
  logic signed [OUT_W-1:0]   y_r;
  logic                      v2_r;
  logic [GAIN_W-1:0]         gain_r;
  logic signed [OUT_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          rd_ptr_r;
  logic [CNT_W-1:0]          count_r;
  logic signed [OUT_W-1:0]   audio_out_r;
  logic                      audio_valid_r;
  logic                      overrun_r;

  // Combinational helpers
  logic                      ev_s;
  logic signed [ACC_W-1:0]   in_ext_s;
  logic signed [ACC_W-1:0]   dc_full_s;
  logic signed [ACC_W-1:0]   x_full_s;
  logic signed [X_W-1:0]     x_s;
  logic signed [ACC_W-1:0]   x_ext_s;
  logic signed [P_W-1:0]     p_s;
  logic signed [P_W-1:0]     y_s;
  logic [OUT_W:0]            mag_s;
  logic [GAIN_W-1:0]         gain_dec_s;
  logic [GAIN_W:0]           gain_att_s;
  logic [GAIN_W-1:0]         gain_inc_s;
  logic [GAIN_W:0]           gain_dcy_s;
  logic [GAIN_W-1:0]         gain_nxt_s;
  logic                      do_pop_s;
  logic                      do_push_s;
  logic                      drop_s;
  logic [CNT_W-1:0]          count_nxt_s;
  logic [CNT_W-1:0]          remain_s;
  logic [PTR_W-1:0]          rd_ptr_nxt_s;
  logic signed [OUT_W-1:0]   audio_out_nxt_s;

  assign ev_s      = demod_clk & ~demod_clk_d_r;
  assign in_ext_s  = {{(ACC_W-IN_W){demod_in[IN_W-1]}}, demod_in};
  assign x_ext_s   = {{(ACC_W-X_W){x_s[X_W-1]}}, x_s};
  assign p_s       = x_r * $signed({1'b0, gain_r});
  assign y_s       = p_s >>> GAIN_FRAC;

  // Stage-1 arithmetic: subtract the tracked DC estimate from the new sample.
  always_comb begin
    dc_full_s = dc_acc_r >>> DC_SHIFT;
    x_full_s  = in_ext_s - dc_full_s;
    x_s       = x_full_s[X_W-1:0];
  end

  // Gain update: fast attack when the output is loud, slow decay otherwise, both clamped.
  always_comb begin
    mag_s      = abs_out(y_r);
    gain_dec_s = gain_r >> ATTACK_SHIFT;
    gain_att_s = {1'b0, gain_r - gain_dec_s};
    if (gain_att_s < GAIN_MIN_C) begin
      gain_att_s = GAIN_MIN_C;
    end else begin
      gain_att_s = gain_att_s;
    end
    gain_inc_s = gain_r >> DECAY_SHIFT;
    if (gain_inc_s == {GAIN_W{1'b0}}) begin
      gain_inc_s = GAIN_ONE_C;
    end else begin
      gain_inc_s = gain_inc_s;
    end
    gain_dcy_s = {1'b0, gain_r} + {1'b0, gain_inc_s};
    if (gain_dcy_s > GAIN_MAX_C) begin
      gain_dcy_s = GAIN_MAX_C;
    end else begin
      gain_dcy_s = gain_dcy_s;
    end
    if (mag_s > TARGET_C) begin
      gain_nxt_s = gain_att_s[GAIN_W-1:0];
    end else begin
      gain_nxt_s = gain_dcy_s[GAIN_W-1:0];
    end
  end

  // FIFO control and next head value; the head register follows the entry that
  // will sit at the read pointer after this cycle's push/pop.
  always_comb begin
    do_pop_s     = (count_r != CNT_ZERO_C) & audio_ready;
    do_push_s    = v2_r & ((count_r != FIFO_FULL_C) | do_pop_s);
    drop_s       = v2_r & ~do_push_s;
    remain_s     = count_r - {{(CNT_W-1){1'b0}}, do_pop_s};
    count_nxt_s  = remain_s + {{(CNT_W-1){1'b0}}, do_push_s};
    rd_ptr_nxt_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, do_pop_s};
    if (count_nxt_s == CNT_ZERO_C) begin
      audio_out_nxt_s = audio_out_r;
    end else if (remain_s == CNT_ZERO_C) begin
      audio_out_nxt_s = y_r;
    end else begin
      audio_out_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Edge detector and stage 1: DC tracker update and DC-removed sample capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      demod_clk_d_r <= 1'b1;
      dc_acc_r      <= {ACC_W{1'b0}};
      x_r           <= {X_W{1'b0}};
      v1_r          <= 1'b0;
    end else begin
      demod_clk_d_r <= demod_clk;
      v1_r          <= ev_s;
      if (ev_s) begin
        x_r      <= x_s;
        dc_acc_r <= dc_acc_r + x_ext_s;
      end else begin
        x_r      <= x_r;
        dc_acc_r <= dc_acc_r;
      end
    end
  end

  // Stage 2: apply the current gain and saturate into the audio range.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r  <= {OUT_W{1'b0}};
      v2_r <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        y_r <= sat_out(y_s);
      end else begin
        y_r <= y_r;
      end
    end
  end

  // Stage 3 gain register: updated for every sample, including dropped ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_r <= GAIN_INIT_C;
    end else if (v2_r) begin
      gain_r <= gain_nxt_s;
    end else begin
      gain_r <= gain_r;
    end
  end

  // FIFO storage: write the stage-2 result at the write pointer on a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {OUT_W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= y_r;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy, registered head/valid and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= CNT_ZERO_C;
      audio_out_r   <= {OUT_W{1'b0}};
      audio_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_ptr_r + {{(PTR_W-1){1'b0}}, do_push_s};
      rd_ptr_r      <= rd_ptr_nxt_s;
      count_r       <= count_nxt_s;
      audio_out_r   <= audio_out_nxt_s;
      audio_valid_r <= (count_nxt_s != CNT_ZERO_C);
      overrun_r     <= overrun_r | drop_s;
    end
  end

  assign audio_out   = audio_out_r;
  assign audio_valid = audio_valid_r;
  assign gain_out    = gain_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_am_audio_agc.sv
// Self-checking bench for am_audio_agc: directed scenarios plus randomized
// samples and sink backpressure, compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_am_audio_agc;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] demod_in;
  logic               demod_clk;
  logic signed [15:0] audio_out;
  logic               audio_valid;
  logic               audio_ready;
  logic [15:0]        gain_out;
  logic               overrun;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  bit rand_ready = 1'b0;
  int ready_pct = 75;

  am_audio_agc dut (
    .clk(clk), .rst(rst), .demod_in(demod_in), .demod_clk(demod_clk),
    .audio_out(audio_out), .audio_valid(audio_valid), .audio_ready(audio_ready),
    .gain_out(gain_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  longint m_gain = 256;
  longint m_dcacc = 0;
  longint m_q[$];
  longint m_last = 0;
  bit     m_over = 1'b0;
  bit     m_prev = 1'b1;
  bit     m_pend = 1'b0;
  longint m_pend_y = 0;
  longint m_pend_at = 0;
  longint m_cyc = 0;

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Model: one step per clk rising edge, following the behavioural rules directly.
  always @(posedge clk) begin
    longint dc, x, y, mag, g, inc;
    bit pop, push;
    if (rst) begin
      m_gain = 256; m_dcacc = 0; m_q.delete(); m_last = 0;
      m_over = 1'b0; m_prev = 1'b1; m_pend = 1'b0;
    end else begin
      pop  = (m_q.size() > 0) && audio_ready;
      push = m_pend && (m_pend_at == m_cyc);
      if (push) begin
        m_pend = 1'b0;
        y   = m_pend_y;
        mag = (y < 0) ? -y : y;
        g   = m_gain;
        if (mag > 16384) begin
          g = g - (g / 16);
          if (g < 16) g = 16;
        end else begin
          inc = g / 1024;
          if (inc < 1) inc = 1;
          g = g + inc;
          if (g > 65535) g = 65535;
        end
        m_gain = g;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 4) m_q.push_back(m_pend_y);
        else m_over = 1'b1;
      end
      if (m_q.size() > 0) m_last = m_q[0];
      if (demod_clk && !m_prev) begin
        dc = m_dcacc >>> 10;
        x  = longint'(demod_in) - dc;
        m_dcacc = m_dcacc + x;
        y = clamp16((x * m_gain) >>> 8);
        m_pend = 1'b1; m_pend_y = y; m_pend_at = m_cyc + 2;
      end
      m_prev = demod_clk;
    end
    m_cyc++;
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("model_valid", longint'(audio_valid), longint'(m_q.size() > 0));
      check_eq("model_out", longint'(audio_out), m_last);
      check_eq("model_gain", longint'(gain_out), m_gain);
      check_eq("model_overrun", longint'(overrun), longint'(m_over));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (rand_ready) audio_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One sample event; returns at the negedge just after the stage-3 landing edge.
  task automatic send(input logic signed [17:0] v, input bit ready_at_land);
    demod_in  = v;
    demod_clk = 1'b1;
    tick();
    demod_clk = 1'b0;
    tick();
    if (ready_at_land) audio_ready = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] r;
    int cnt;
    rst = 1'b1; demod_clk = 1'b1; demod_in = '0; audio_ready = 1'b0;
    idle(2);
    chk_en = 1'b1;
    // Reset with demod_clk held high; release must not produce an event.
    rst = 1'b0;
    idle(4);
    check_eq("rst_valid", longint'(audio_valid), 0);
    check_eq("rst_out", longint'(audio_out), 0);
    check_eq("rst_gain", longint'(gain_out), 256);
    check_eq("rst_overrun", longint'(overrun), 0);
    demod_clk = 1'b0;
    idle(2);

    // Single samples at unity gain, then the decayed gain.
    audio_ready = 1'b1;
    send(18'sd1000, 1'b0);
    check_eq("s1_valid", longint'(audio_valid), 1);
    check_eq("s1_out", longint'(audio_out), 1000);
    check_eq("s1_gain", longint'(gain_out), 257);
    idle(3);
    send(18'sd1000, 1'b0);
    check_eq("s2_out", longint'(audio_out), 1003);
    check_eq("s2_gain", longint'(gain_out), 258);
    idle(3);

    // Saturation and attack in both directions.
    do_reset();
    send(18'sd131071, 1'b0);
    check_eq("sat_pos_out", longint'(audio_out), 32767);
    check_eq("sat_pos_gain", longint'(gain_out), 240);
    idle(3);
    send(-18'sd131072, 1'b0);
    check_eq("sat_neg_out", longint'(audio_out), -32768);
    check_eq("sat_neg_gain", longint'(gain_out), 225);
    idle(3);

    // Backpressure: five samples into a four-entry FIFO.
    do_reset();
    audio_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send(18'(v), 1'b0);
      idle(5);
    end
    check_eq("bp_overrun", longint'(overrun), 1);
    audio_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_valid", longint'(audio_valid), 1);
      check_eq("bp_order", longint'(audio_out), longint'(i + 1));
      tick();
    end
    check_eq("bp_empty", longint'(audio_valid), 0);
    check_eq("bp_overrun_sticky", longint'(overrun), 1);
    idle(2);

    // Full FIFO with a pop on the very cycle a push lands.
    do_reset();
    audio_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      send(18'(v), 1'b0);
      idle(2);
    end
    send(18'sd5, 1'b1);
    audio_ready = 1'b0;
    check_eq("fp_overrun", longint'(overrun), 0);
    check_eq("fp_head", longint'(audio_out), 2);
    audio_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (audio_valid) cnt++;
      tick();
    end
    check_eq("fp_count", longint'(cnt), 4);

    // Reset one edge after an event discards the in-flight sample.
    do_reset();
    demod_in = 18'sd5000; demod_clk = 1'b1;
    tick();
    rst = 1'b1; demod_clk = 1'b0;
    tick();
    rst = 1'b0;
    idle(5);
    check_eq("mid_rst_valid", longint'(audio_valid), 0);
    check_eq("mid_rst_gain", longint'(gain_out), 256);

    // Randomized samples and sink behaviour.
    rand_ready = 1'b1;
    for (int blk = 0; blk < 4; blk++) begin
      case (blk)
        0: ready_pct = 90;
        1: ready_pct = 15;
        2: ready_pct = 50;
        default: ready_pct = 100;
      endcase
      for (int k = 0; k < 20; k++) begin
        case ($urandom_range(0, 2))
          0: r = 18'($urandom);
          1: r = 18'($signed($urandom_range(0, 4000)) - 2000);
          default: r = 18'($signed($urandom_range(0, 40000)) - 20000);
        endcase
        send($signed(r), 1'b0);
        idle($urandom_range(1, 8));
      end
    end
    rand_ready = 1'b0;
    audio_ready = 1'b1;
    idle(8);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
